// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: selects ALU or extracted/extended load data, waits for
// multi-cycle memory responses. Optional stall counter enabled by macro MEM_WB_PERF_EN.
module mem_wb_stage #(
  parameter int WordSize    = 32,
  parameter int RegAddrBits = 5,
  localparam int OffBits    = $clog2(WordSize / 8)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             wbs,
  input  logic [RegAddrBits-1:0] rdn_in,
  input  logic [OffBits-1:0]     addr_lo,
  input  logic [WordSize-1:0]    alu_out,
  input  logic [WordSize-1:0]    mrd,
  input  logic                   mrd_valid,
  output logic                   out_valid,
  output logic                   rd_we,
  output logic [RegAddrBits-1:0] rdn,
  output logic [WordSize-1:0]    rdd,
  output logic                   misalign
`ifdef MEM_WB_PERF_EN
  ,
  output logic [31:0]            stall_cnt
`endif
);

  localparam logic STATE_IDLE     = 1'b0;
  localparam logic STATE_WAIT_MEM = 1'b1;

  logic                   state_q, state_d;
  logic [2:0]             wbs_q, wbs_d;
  logic [RegAddrBits-1:0] rdn_l_q, rdn_l_d;
  logic [OffBits-1:0]     off_q, off_d;
  logic                   out_valid_q, out_valid_d;
  logic                   rd_we_q, rd_we_d;
  logic [RegAddrBits-1:0] rdn_q, rdn_d;
  logic [WordSize-1:0]    rdd_q, rdd_d;
  logic                   misalign_q, misalign_d;

  logic                   accept;
  logic                   complete;
  logic [2:0]             op_wbs;
  logic [RegAddrBits-1:0] op_rdn;
  logic [OffBits-1:0]     op_off;
  logic                   op_is_load;
  logic                   op_writes;
  logic                   op_mis;
  logic [WordSize-1:0]    shifted;
  logic [WordSize-1:0]    wb_data;

  assign in_ready = (state_q == STATE_IDLE);

  // In IDLE the op comes straight from MEM; in WAIT_MEM it comes from the latch.
  always_comb begin
    accept     = in_valid && in_ready && !flush;
    op_wbs     = in_ready ? wbs     : wbs_q;
    op_rdn     = in_ready ? rdn_in  : rdn_l_q;
    op_off     = in_ready ? addr_lo : off_q;
    op_is_load = (op_wbs != 3'd3) && (op_wbs != 3'd7) &&
                 !((op_wbs == 3'd6) && (WordSize != 64));
    op_writes  = op_is_load || (op_wbs == 3'd3);
    op_mis     = (((op_wbs == 3'd1) || (op_wbs == 3'd5)) && op_off[0]) ||
                 (((op_wbs == 3'd2) || ((op_wbs == 3'd6) && (WordSize == 64))) &&
                  (op_off[1:0] != 2'b00));
    complete   = (accept && (!op_is_load || mrd_valid)) ||
                 (!in_ready && mrd_valid && !flush);
    shifted    = mrd >> {op_off, 3'b000};

    wb_data = '0;
    case (op_wbs)
      3'd0: wb_data = WordSize'($signed(shifted[7:0]));
      3'd1: wb_data = WordSize'($signed(shifted[15:0]));
      3'd2: wb_data = WordSize'($signed(shifted[31:0]));
      3'd3: wb_data = alu_out;
      3'd4: wb_data = WordSize'(shifted[7:0]);
      3'd5: wb_data = WordSize'(shifted[15:0]);
      3'd6: wb_data = (WordSize == 64) ? WordSize'(shifted[31:0]) : '0;
      default: wb_data = '0;
    endcase
    if (op_mis) begin
      wb_data = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    wbs_d       = wbs_q;
    rdn_l_d     = rdn_l_q;
    off_d       = off_q;
    out_valid_d = complete;
    rd_we_d     = complete && op_writes && !op_mis && (op_rdn != '0);
    misalign_d  = complete && op_mis;
    rdn_d       = rdn_q;
    rdd_d       = rdd_q;

    if (complete) begin
      rdn_d = op_rdn;
      rdd_d = wb_data;
    end

    // Flush wins over everything, including a response arriving in WAIT_MEM.
    if (flush) begin
      state_d = STATE_IDLE;
    end else if (accept && op_is_load && !mrd_valid) begin
      state_d = STATE_WAIT_MEM;
      wbs_d   = wbs;
      rdn_l_d = rdn_in;
      off_d   = addr_lo;
    end else if (!in_ready && mrd_valid) begin
      state_d = STATE_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= STATE_IDLE;
      wbs_q       <= '0;
      rdn_l_q     <= '0;
      off_q       <= '0;
      out_valid_q <= 1'b0;
      rd_we_q     <= 1'b0;
      rdn_q       <= '0;
      rdd_q       <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wbs_q       <= wbs_d;
      rdn_l_q     <= rdn_l_d;
      off_q       <= off_d;
      out_valid_q <= out_valid_d;
      rd_we_q     <= rd_we_d;
      rdn_q       <= rdn_d;
      rdd_q       <= rdd_d;
      misalign_q  <= misalign_d;
    end
  end

  assign out_valid = out_valid_q;
  assign rd_we     = rd_we_q;
  assign rdn       = rdn_q;
  assign rdd       = rdd_q;
  assign misalign  = misalign_q;

`ifdef MEM_WB_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of WAIT_MEM edges with no response; only reset clears it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == STATE_WAIT_MEM) && !mrd_valid && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
